pid_ctrl_param: RTL and testbench

Parametrised balance-loop PID controller for the Segway datapath. It sits between the inertial interface, which supplies `ptch`, `ptch_rt` and `vld`, and the motor-drive mixing logic, which consumes `PID_cntrl`. It generalises the fixed-gain PID in four ways: widths are parametrised, the P gain is a run-time input, the output path is a two-stage registered pipeline with a valid strobe, and a selectable anti-windup mode freezes the integrator while the output is saturated.

---
 rtl/pid_ctrl_param.sv | 174 +++++++++++++++++
 tb/tb_pid_ctrl_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl_param.sv
// Parametrised balance-loop PID controller.
// Stage 1 registers the saturated pitch error and the negated, scaled pitch
// rate; stage 2 forms P + I + D at full width and saturates it onto PID_cntrl
// with a one-cycle valid strobe. A saturating integrator with optional
// conditional-freeze anti-windup and a non-wrapping soft-start timer run
// alongside the pipeline.
module pid_ctrl_param #(
  parameter int IN_W        = 16,
  parameter int ERR_W       = 10,
  parameter int INT_W       = 18,
  parameter int I_SHIFT     = 6,
  parameter int D_SHIFT     = 6,
  parameter int OUT_W       = 12,
  parameter int SS_W        = 27,
  parameter int SS_OUT_W    = 8,
  parameter int SS_INC_SLOW = 1,
  parameter int SS_INC_FAST = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic signed [IN_W-1:0]  ptch,
  input  logic signed [IN_W-1:0]  ptch_rt,
  input  logic        [4:0]       p_coeff,
  input  logic                    i_en,
  input  logic                    aw_mode,
  input  logic                    pwr_up,
  input  logic                    ss_fast,
  input  logic                    rider_off,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    cntrl_vld,
  output logic                    out_sat,
  output logic                    int_sat,
  output logic [SS_OUT_W-1:0]     ss_tmr
);

  // Derived widths: P product, I term, D term and a sum wide enough that
  // adding all three can never wrap.
  localparam int PC_W   = 5;
  localparam int P_W    = ERR_W + PC_W + 1;
  localparam int I_W    = INT_W - I_SHIFT;
  localparam int D_W    = IN_W - D_SHIFT + 1;
  localparam int MAX_PI = (P_W > I_W) ? P_W : I_W;
  localparam int MAX_W  = (MAX_PI > D_W) ? MAX_PI : D_W;
  localparam int SUM_W  = MAX_W + 2;

  localparam logic signed [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [SS_W:0]           INC_SLOW = (SS_W+1)'(SS_INC_SLOW);
  localparam logic [SS_W:0]           INC_FAST = (SS_W+1)'(SS_INC_FAST);

  // State
  logic signed [ERR_W-1:0] err_q,    err_d;
  logic signed [D_W-1:0]   d_q,      d_d;
  logic                    v1_q,     v1_d;
  logic signed [INT_W-1:0] integ_q,  integ_d;
  logic signed [OUT_W-1:0] pid_q,    pid_d;
  logic                    cvld_q,   cvld_d;
  logic                    osat_q,   osat_d;
  logic [SS_W-1:0]         ss_q,     ss_d;

  // Combinational intermediates
  logic signed [ERR_W-1:0] err_sat;
  logic signed [D_W-1:0]   rt_ext;
  logic [INT_W:0]          int_sum;
  logic                    frozen;
  logic signed [P_W-1:0]   p_term;
  logic signed [I_W-1:0]   i_term;
  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] sum_sat;
  logic [SS_W:0]           ss_sum;

  // Stage 1: clip pitch to ERR_W and capture error and negated D term on vld.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    err_sat = ptch[ERR_W-1:0];
    // Value fits only when all bits above the ERR_W sign bit match it.
    if (!(&ptch[IN_W-1:ERR_W-1]) && (|ptch[IN_W-1:ERR_W-1]))
      err_sat = ptch[IN_W-1] ? ERR_MIN : ERR_MAX;
    // ptch_rt >>> D_SHIFT keeps IN_W-D_SHIFT significant bits; one extra
    // bit lets the negation of the most negative rate fit.
    rt_ext = {ptch_rt[IN_W-1], ptch_rt[IN_W-1:D_SHIFT]};
    err_d  = err_q;
    d_d    = d_q;
    v1_d   = vld;
    if (vld) begin
      err_d = err_sat;
      d_d   = -rt_ext;
    end
  end

  // Integrator: rider_off clear, else saturating accumulate unless frozen.
  always_comb begin
    int_sum = {integ_q[INT_W-1], integ_q}
            + {{(INT_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};
    // Freeze uses the registered output, so it lags saturation by one sample.
    frozen  = aw_mode && osat_q && (err_sat != '0)
            && (err_sat[ERR_W-1] == pid_q[OUT_W-1]);
    integ_d = integ_q;
    if (rider_off) begin
      integ_d = '0;
    end else if (vld && i_en && !frozen) begin
      if (int_sum[INT_W] != int_sum[INT_W-1])
        integ_d = int_sum[INT_W] ? INT_MIN : INT_MAX;
      else
        integ_d = int_sum[INT_W-1:0];
    end
  end

  // Stage 2: full-width P + I + D, saturated to OUT_W, with valid strobe.
  always_comb begin
    p_term  = $signed({{(PC_W+1){err_q[ERR_W-1]}}, err_q})
            * $signed({{(P_W-PC_W){1'b0}}, p_coeff});
    i_term  = integ_q[INT_W-1:I_SHIFT];
    sum     = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_q);
    sum_sat = sum[OUT_W-1:0];
    if (!(&sum[SUM_W-1:OUT_W-1]) && (|sum[SUM_W-1:OUT_W-1]))
      sum_sat = sum[SUM_W-1] ? OUT_MIN : OUT_MAX;
    pid_d  = pid_q;
    osat_d = osat_q;
    cvld_d = v1_q;
    if (v1_q) begin
      pid_d  = sum_sat;
      osat_d = (sum_sat == OUT_MAX) || (sum_sat == OUT_MIN);
    end
  end

  // Soft start: cleared while powered down, otherwise climbs and sticks at all-ones.
  always_comb begin
    ss_sum = {1'b0, ss_q} + (ss_fast ? INC_FAST : INC_SLOW);
    ss_d   = ss_q;
    if (!pwr_up)
      ss_d = '0;
    else if (ss_sum[SS_W])
      ss_d = '1;
    else
      ss_d = ss_sum[SS_W-1:0];
  end

  // State registers, all cleared by the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      d_q     <= '0;
      v1_q    <= 1'b0;
      integ_q <= '0;
      pid_q   <= '0;
      cvld_q  <= 1'b0;
      osat_q  <= 1'b0;
      ss_q    <= '0;
    end else begin
      err_q   <= err_d;
      d_q     <= d_d;
      v1_q    <= v1_d;
      integ_q <= integ_d;
      pid_q   <= pid_d;
      cvld_q  <= cvld_d;
      osat_q  <= osat_d;
      ss_q    <= ss_d;
    end
  end

  assign PID_cntrl = pid_q;
  assign cntrl_vld = cvld_q;
  assign out_sat   = osat_q;
  assign int_sat   = (integ_q == INT_MAX) || (integ_q == INT_MIN);
  assign ss_tmr    = ss_q[SS_W-1 -: SS_OUT_W];

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Self-checking bench for pid_ctrl_param: table-driven pipeline vectors,
// hand-written anti-windup / integrator / reset / soft-start sequences, and a
// scoreboard queue compared on every cntrl_vld strobe.
module tb_pid_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic [4:0]  p_coeff;
  logic        i_en, aw_mode, pwr_up, ss_fast, rider_off;
  logic        pwr_up2, ss_fast2;
  logic [11:0] PID_cntrl;
  logic        cntrl_vld, out_sat, int_sat;
  logic [7:0]  ss_tmr;
  logic [11:0] pid2;
  logic        cvld2, osat2, isat2;
  logic [3:0]  ss_tmr2;

  always #5 clk = ~clk;

  pid_ctrl_param dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .p_coeff(p_coeff), .i_en(i_en), .aw_mode(aw_mode), .pwr_up(pwr_up),
    .ss_fast(ss_fast), .rider_off(rider_off), .PID_cntrl(PID_cntrl),
    .cntrl_vld(cntrl_vld), .out_sat(out_sat), .int_sat(int_sat), .ss_tmr(ss_tmr)
  );

  // Small soft-start instance so the all-ones hold is reachable quickly.
  pid_ctrl_param #(.SS_W(10), .SS_OUT_W(4), .SS_INC_SLOW(1), .SS_INC_FAST(100)) dut_ss (
    .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .p_coeff(p_coeff), .i_en(i_en), .aw_mode(aw_mode), .pwr_up(pwr_up2),
    .ss_fast(ss_fast2), .rider_off(rider_off), .PID_cntrl(pid2),
    .cntrl_vld(cvld2), .out_sat(osat2), .int_sat(isat2), .ss_tmr(ss_tmr2)
  );

  typedef struct {
    string       name;
    logic [15:0] ptch;
    logic [15:0] rt;
    logic [4:0]  p;
    logic [11:0] pid;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [11:0] pid;
    logic        sat;
  } exp_t;

  exp_t  sb_q[$];
  vec_t  vecs[13];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%s]: got 0x%0h expected 0x%0h", name, cur_tag, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && cntrl_vld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe [%s]: got PID 0x%0h with no pending sample", cur_tag, PID_cntrl);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pid", 32'(PID_cntrl), 32'(e.pid));
        check("sb_out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  // Drive one vld sample across one edge and queue its expected output.
  task automatic sample(input logic [15:0] p, input logic [15:0] rt,
                        input logic [11:0] e_pid, input logic e_sat);
    exp_t e;
    e.pid = e_pid;
    e.sat = e_sat;
    ptch    = p;
    ptch_rt = rt;
    vld     = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fill the integrator from a clean, unsaturated state, then apply a zero-error sample.
  task automatic aw_run(input logic mode, input logic [11:0] exp_last);
    i_en = 1'b0; aw_mode = mode; p_coeff = 5'd0; rider_off = 1'b1;
    sample(16'h0000, 16'h0000, 12'h000, 1'b0);
    rider_off = 1'b0;
    idle(2);
    p_coeff = 5'd9; i_en = 1'b1;
    repeat (3) sample(16'h00FF, 16'h0000, 12'h7FF, 1'b1);
    sample(16'h0000, 16'h0000, exp_last, 1'b0);
    i_en = 1'b0;
    idle(3);
  endtask

  initial begin
    vecs[0]  = '{name:"p_basic",      ptch:16'h0002, rt:16'h0000, p:5'd9,  pid:12'h012, sat:1'b0};
    vecs[1]  = '{name:"d_pos_rate",   ptch:16'h0002, rt:16'h0100, p:5'd9,  pid:12'h00E, sat:1'b0};
    vecs[2]  = '{name:"pos_sat",      ptch:16'h00FF, rt:16'h0100, p:5'd9,  pid:12'h7FF, sat:1'b1};
    vecs[3]  = '{name:"neg_clip",     ptch:16'h8000, rt:16'h0100, p:5'd9,  pid:12'h800, sat:1'b1};
    vecs[4]  = '{name:"neg_err_rate", ptch:16'hFFFE, rt:16'hFF00, p:5'd31, pid:12'hFC6, sat:1'b0};
    vecs[5]  = '{name:"near_max",     ptch:16'h7FFF, rt:16'h0000, p:5'd4,  pid:12'h7FC, sat:1'b0};
    vecs[6]  = '{name:"at_max",       ptch:16'h0200, rt:16'hFF40, p:5'd4,  pid:12'h7FF, sat:1'b1};
    vecs[7]  = '{name:"at_min",       ptch:16'hFE00, rt:16'h0000, p:5'd4,  pid:12'h800, sat:1'b1};
    vecs[8]  = '{name:"near_min",     ptch:16'hFE01, rt:16'h0040, p:5'd4,  pid:12'h803, sat:1'b0};
    vecs[9]  = '{name:"d_min_rate",   ptch:16'h0000, rt:16'h8000, p:5'd0,  pid:12'h200, sat:1'b0};
    vecs[10] = '{name:"big_rate_sat", ptch:16'h7FFF, rt:16'h7FFF, p:5'd31, pid:12'h7FF, sat:1'b1};
    vecs[11] = '{name:"rt_minus1",    ptch:16'h0005, rt:16'hFFFF, p:5'd31, pid:12'h09C, sat:1'b0};
    vecs[12] = '{name:"p_zero",       ptch:16'h0123, rt:16'h0000, p:5'd0,  pid:12'h000, sat:1'b0};

    rst = 1'b0; vld = 1'b0; ptch = '0; ptch_rt = '0; p_coeff = '0;
    i_en = 1'b0; aw_mode = 1'b0; pwr_up = 1'b0; ss_fast = 1'b0; rider_off = 1'b0;
    pwr_up2 = 1'b0; ss_fast2 = 1'b0;
    #1 rst = 1'b1;
    #11;
    cur_tag = "reset";
    check("rst_pid", 32'(PID_cntrl), 0);
    check("rst_cntrl_vld", 32'(cntrl_vld), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_int_sat", 32'(int_sat), 0);
    check("rst_ss_tmr", 32'(ss_tmr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: vld held high, first strobe two edges after the first vld.
    cur_tag = "latency";
    p_coeff = 5'd9;
    for (int i = 0; i < 4; i++) begin
      sample(16'h0002, 16'h0000, 12'h012, 1'b0);
      if (i == 0) check("lat_no_strobe_e", 32'(cntrl_vld), 0);
      if (i == 1) begin
        check("lat_strobe_e1", 32'(cntrl_vld), 1);
        check("lat_pid_e1", 32'(PID_cntrl), 32'h012);
      end
    end
    idle(3);

    // Table vectors, one sample each, then confirm output holds between strobes.
    foreach (vecs[k]) begin
      cur_tag = vecs[k].name;
      p_coeff = vecs[k].p;
      sample(vecs[k].ptch, vecs[k].rt, vecs[k].pid, vecs[k].sat);
      idle(2);
      check("hold_pid", 32'(PID_cntrl), 32'(vecs[k].pid));
      check("hold_no_strobe", 32'(cntrl_vld), 0);
    end

    cur_tag = "aw_freeze";
    aw_run(1'b1, 12'h007);
    cur_tag = "aw_clamp_only";
    aw_run(1'b0, 12'h00B);

    // Positive integrator rail.
    cur_tag = "int_pos_rail";
    aw_mode = 1'b0; i_en = 1'b1; p_coeff = 5'd9;
    repeat (300) sample(16'h01FF, 16'h0000, 12'h7FF, 1'b1);
    i_en = 1'b0;
    idle(2);
    check("int_sat_pos", 32'(int_sat), 1);
    p_coeff = 5'd0;
    sample(16'h0000, 16'h0000, 12'h7FF, 1'b1);
    idle(2);
    rider_off = 1'b1;
    @(posedge clk); #1;
    rider_off = 1'b0;
    check("int_sat_after_rider_off", 32'(int_sat), 0);
    sample(16'h0000, 16'h0000, 12'h000, 1'b0);
    idle(2);

    // Negative integrator rail.
    cur_tag = "int_neg_rail";
    i_en = 1'b1; p_coeff = 5'd9;
    repeat (300) sample(16'hFE00, 16'h0000, 12'h800, 1'b1);
    i_en = 1'b0;
    idle(2);
    check("int_sat_neg", 32'(int_sat), 1);
    p_coeff = 5'd0;
    sample(16'h0000, 16'h0000, 12'h800, 1'b1);
    idle(2);
    rider_off = 1'b1;
    @(posedge clk); #1;
    rider_off = 1'b0;
    check("int_sat_neg_cleared", 32'(int_sat), 0);

    // Reset mid-operation with a sample in flight.
    cur_tag = "mid_reset";
    p_coeff = 5'd9;
    sample(16'h0002, 16'h0000, 12'h012, 1'b0);
    idle(2);
    ptch = 16'h0005; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_pid", 32'(PID_cntrl), 0);
    check("mid_rst_cntrl_vld", 32'(cntrl_vld), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    check("post_rst_no_strobe", 32'(cntrl_vld), 0);
    check("post_rst_pid", 32'(PID_cntrl), 0);
    sample(16'h0002, 16'h0000, 12'h012, 1'b0);
    idle(2);

    // Soft start on the full-size instance.
    cur_tag = "soft_start";
    pwr_up = 1'b0;
    repeat (2200) @(posedge clk);
    #1;
    check("ss_off", 32'(ss_tmr), 0);
    pwr_up = 1'b1; ss_fast = 1'b1;
    repeat (2047) @(posedge clk);
    #1;
    check("ss_fast_2047", 32'(ss_tmr), 0);
    @(posedge clk); #1;
    check("ss_fast_2048", 32'(ss_tmr), 1);
    pwr_up = 1'b0;
    @(posedge clk); #1;
    check("ss_cleared", 32'(ss_tmr), 0);

    // Soft-start all-ones hold on the small instance (acc steps of 100 in 10 bits).
    cur_tag = "soft_start_small";
    pwr_up2 = 1'b1; ss_fast2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("ss2_5", 32'(ss_tmr2), 7);
    repeat (6) @(posedge clk);
    #1;
    check("ss2_11_no_wrap", 32'(ss_tmr2), 15);
    repeat (9) @(posedge clk);
    #1;
    check("ss2_20_held", 32'(ss_tmr2), 15);
    pwr_up2 = 1'b0;
    @(posedge clk); #1;
    check("ss2_cleared", 32'(ss_tmr2), 0);
    pwr_up2 = 1'b1; ss_fast2 = 1'b0;
    repeat (63) @(posedge clk);
    #1;
    check("ss2_slow_63", 32'(ss_tmr2), 0);
    @(posedge clk); #1;
    check("ss2_slow_64", 32'(ss_tmr2), 1);

    cur_tag = "end";
    idle(2);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
